// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for the RV32I core: decodes IMEM instructions into the control
// bundle, carries it through EX/MEM/WB, and sequences stalls, flushes and forwarding.
module pipe_ctrl_unit #(
  parameter int unsigned INST_W = 32,
  parameter int unsigned CTRL_W = 11,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  input  logic [INST_W-1:0] inst,
  output logic              inst_ready,
  input  logic              flush,
  input  logic              mem_stall,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic [CTRL_W-1:0] ctrl_mem,
  output logic [CTRL_W-1:0] ctrl_wb,
  output logic [2:0]        funct3_ex,
  output logic [2:0]        funct3_mem,
  output logic [4:0]        rd_wb,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              illegal
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } opcode_e;

  localparam int unsigned WEN = 0;
  localparam int unsigned LDM = 6;

  logic              id_valid;
  logic [6:0]        id_op;
  logic [4:0]        id_rd, id_rs1, id_rs2;
  logic [2:0]        id_f3;

  logic              ex_valid, mem_valid, wb_valid;
  logic [CTRL_W-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [2:0]        ex_f3, mem_f3;
  logic [4:0]        ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2;
  logic              illegal_q;

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_ill, use_rs1, use_rs2;
  logic [4:0]        src1, src2, dec_rd;
  logic              hazard_stall, ex_take;
  logic              unused_inst_hi;

  assign unused_inst_hi = ^inst[INST_W-1:25];

  function automatic logic rd_hits(input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2);
    return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

  function automatic logic fwd_hit(input logic v, input logic w, input logic [4:0] rd,
                                   input logic [4:0] rs);
    return v && w && (rs != 5'd0) && (rd == rs);
  endfunction

  always_comb begin
    dec_ctrl = '0;
    dec_ill  = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (id_op)
      OP_R:      begin dec_ctrl = 11'h611; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_IALU:   begin dec_ctrl = 11'h711; use_rs1 = 1'b1; end
      OP_LOAD:
        if (id_f3 == 3'b011 || id_f3 == 3'b110 || id_f3 == 3'b111) dec_ill = 1'b1;
        else begin dec_ctrl = 11'h7D9; use_rs1 = 1'b1; end
      OP_STORE:
        if (id_f3 > 3'b010) dec_ill = 1'b1;
        else begin dec_ctrl = 11'h798; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_BRANCH:
        if (id_f3 == 3'b010 || id_f3 == 3'b011) dec_ill = 1'b1;
        else begin dec_ctrl = 11'h532; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_LUI:    dec_ctrl = 11'h111;
      OP_AUIPC:  dec_ctrl = 11'h311;
      OP_JAL:    dec_ctrl = 11'h113;
      OP_JALR:   begin dec_ctrl = 11'h713; use_rs1 = 1'b1; end
      default:   dec_ill = 1'b1;
    endcase
  end

  // Unused source/destination fields are zeroed so x0 and don't-care bits never match.
  assign src1   = use_rs1 ? id_rs1 : 5'd0;
  assign src2   = use_rs2 ? id_rs2 : 5'd0;
  assign dec_rd = dec_ctrl[WEN] ? id_rd : 5'd0;

  always_comb begin
    hazard_stall = 1'b0;
    if (id_valid) begin
      if (FWD_EN)
        hazard_stall = ex_valid && ex_ctrl[LDM] && rd_hits(ex_rd, src1, src2);
      else
        hazard_stall = (ex_valid  && ex_ctrl[WEN]  && rd_hits(ex_rd,  src1, src2)) ||
                       (mem_valid && mem_ctrl[WEN] && rd_hits(mem_rd, src1, src2)) ||
                       (wb_valid  && wb_ctrl[WEN]  && rd_hits(wb_rd,  src1, src2));
    end
  end

  assign inst_ready = !mem_stall && (flush || !hazard_stall);
  assign ex_take    = !flush && !hazard_stall && id_valid && !dec_ill;

  // Flush kills the ID occupant but still lets ID capture the branch target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid  <= 1'b0;
      id_op     <= '0;
      id_rd     <= '0;
      id_rs1    <= '0;
      id_rs2    <= '0;
      id_f3     <= '0;
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_f3     <= '0;
      ex_rd     <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      mem_valid <= 1'b0;
      mem_ctrl  <= '0;
      mem_f3    <= '0;
      mem_rd    <= '0;
      wb_valid  <= 1'b0;
      wb_ctrl   <= '0;
      wb_rd     <= '0;
      illegal_q <= 1'b0;
    end else if (!mem_stall) begin
      if (flush || !hazard_stall) begin
        id_valid <= inst_valid;
        id_op    <= inst[6:0];
        id_rd    <= inst[11:7];
        id_f3    <= inst[14:12];
        id_rs1   <= inst[19:15];
        id_rs2   <= inst[24:20];
      end
      ex_valid  <= ex_take;
      ex_ctrl   <= ex_take ? dec_ctrl : '0;
      ex_f3     <= ex_take ? id_f3 : 3'd0;
      ex_rd     <= ex_take ? dec_rd : 5'd0;
      ex_rs1    <= ex_take ? src1 : 5'd0;
      ex_rs2    <= ex_take ? src2 : 5'd0;
      illegal_q <= id_valid && dec_ill && !flush && !hazard_stall;
      mem_valid <= ex_valid;
      mem_ctrl  <= ex_ctrl;
      mem_f3    <= ex_f3;
      mem_rd    <= ex_rd;
      wb_valid  <= mem_valid;
      wb_ctrl   <= mem_ctrl;
      wb_rd     <= mem_rd;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN && ex_valid) begin
      if (fwd_hit(mem_valid, mem_ctrl[WEN] && !mem_ctrl[LDM], mem_rd, ex_rs1)) fwd_a = 2'b01;
      else if (fwd_hit(wb_valid, wb_ctrl[WEN], wb_rd, ex_rs1))                fwd_a = 2'b10;
      if (fwd_hit(mem_valid, mem_ctrl[WEN] && !mem_ctrl[LDM], mem_rd, ex_rs2)) fwd_b = 2'b01;
      else if (fwd_hit(wb_valid, wb_ctrl[WEN], wb_rd, ex_rs2))                fwd_b = 2'b10;
    end
  end

  assign ctrl_ex    = ex_ctrl;
  assign ctrl_mem   = mem_ctrl;
  assign ctrl_wb    = wb_ctrl;
  assign funct3_ex  = ex_f3;
  assign funct3_mem = mem_f3;
  assign rd_wb      = wb_rd;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one forwarding instance and one
// no-forwarding instance, checked against hand-computed control values.
module tb_pipe_ctrl_unit;

  localparam logic [31:0] ADDI_X1 = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] LW_X2   = 32'h0000_A103; // lw   x2,0(x1)
  localparam logic [31:0] ADD_X3  = 32'h0011_01B3; // add  x3,x2,x1
  localparam logic [31:0] ADD_X4  = 32'h0010_8233; // add  x4,x1,x1
  localparam logic [31:0] BEQ_I   = 32'h0020_8463; // beq  x1,x2,+8
  localparam logic [31:0] ADDI_X5 = 32'h0010_0293; // addi x5,x0,1
  localparam logic [31:0] SW_I    = 32'h0020_A223; // sw   x2,4(x1)
  localparam logic [31:0] BAD_OP  = 32'h0000_007F;
  localparam logic [31:0] LD_BAD  = 32'h0000_B103; // load funct3=011

  logic        clk, rst_n, inst_valid, flush, mem_stall;
  logic [31:0] inst;
  logic        inst_ready, illegal;
  logic [10:0] ctrl_ex, ctrl_mem, ctrl_wb;
  logic [2:0]  funct3_ex, funct3_mem;
  logic [4:0]  rd_wb;
  logic [1:0]  fwd_a, fwd_b;

  logic        nf_valid, nf_ready, nf_illegal;
  logic [31:0] nf_inst;
  logic [10:0] nf_ctrl_ex, nf_ctrl_mem, nf_ctrl_wb;
  logic [2:0]  nf_f3_ex, nf_f3_mem;
  logic [4:0]  nf_rd_wb;
  logic [1:0]  nf_fwd_a, nf_fwd_b;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned stalls;
  logic        found;

  pipe_ctrl_unit #(.INST_W(32), .CTRL_W(11), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst(inst),
    .inst_ready(inst_ready), .flush(flush), .mem_stall(mem_stall),
    .ctrl_ex(ctrl_ex), .ctrl_mem(ctrl_mem), .ctrl_wb(ctrl_wb),
    .funct3_ex(funct3_ex), .funct3_mem(funct3_mem), .rd_wb(rd_wb),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .illegal(illegal)
  );

  pipe_ctrl_unit #(.INST_W(32), .CTRL_W(11), .FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .inst_valid(nf_valid), .inst(nf_inst),
    .inst_ready(nf_ready), .flush(1'b0), .mem_stall(1'b0),
    .ctrl_ex(nf_ctrl_ex), .ctrl_mem(nf_ctrl_mem), .ctrl_wb(nf_ctrl_wb),
    .funct3_ex(nf_f3_ex), .funct3_mem(nf_f3_mem), .rd_wb(nf_rd_wb),
    .fwd_a(nf_fwd_a), .fwd_b(nf_fwd_b), .illegal(nf_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; inst_valid = 1'b0; inst = '0; flush = 1'b0; mem_stall = 1'b0;
    nf_valid = 1'b0; nf_inst = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl_ex", ctrl_ex, 0);
    chk("rst_ctrl_mem", ctrl_mem, 0);
    chk("rst_ctrl_wb", ctrl_wb, 0);
    chk("rst_f3", {funct3_ex, funct3_mem}, 0);
    chk("rst_rd_wb", rd_wb, 0);
    chk("rst_fwd", {fwd_a, fwd_b}, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_ready", inst_ready, 1);
    chk("rst_nf_ctrl", {nf_ctrl_ex, nf_ctrl_mem, nf_ctrl_wb}, 0);
    chk("rst_nf_misc", {nf_f3_ex, nf_f3_mem, nf_rd_wb, nf_fwd_a, nf_fwd_b, nf_illegal}, 0);
    #2 rst_n = 1'b1;

    // basic latency of one ADDI
    inst_valid = 1'b1; inst = ADDI_X1;
    tick(); inst_valid = 1'b0;
    tick(); chk("t1_ctrl_ex", ctrl_ex, 'h711); chk("t1_f3_ex", funct3_ex, 0);
    tick(); chk("t1_ctrl_mem", ctrl_mem, 'h711); chk("t1_ex_empty", ctrl_ex, 0);
    tick(); chk("t1_ctrl_wb", ctrl_wb, 'h711); chk("t1_rd_wb", rd_wb, 1);
    tick(); chk("t1_wb_empty", ctrl_wb, 0);

    // load-use stall then WB forwarding
    inst_valid = 1'b1; inst = LW_X2;
    tick(); inst = ADD_X3; #1 chk("t2_ready_lw_id", inst_ready, 1);
    tick(); inst_valid = 1'b0;
    chk("t2_ctrl_ex_lw", ctrl_ex, 'h7D9); chk("t2_f3_ex", funct3_ex, 2);
    chk("t2_ready_stall", inst_ready, 0);
    tick(); chk("t2_bubble", ctrl_ex, 0); chk("t2_ctrl_mem", ctrl_mem, 'h7D9);
    chk("t2_f3_mem", funct3_mem, 2); chk("t2_ready_after", inst_ready, 1);
    tick(); chk("t2_add_ex", ctrl_ex, 'h611); chk("t2_fwd_a", fwd_a, 2'b10);
    chk("t2_fwd_b", fwd_b, 2'b00); chk("t2_rd_wb", rd_wb, 2);
    repeat (3) tick();

    // ALU-ALU dependence with forwarding: no stall, MEM forward on both operands
    inst_valid = 1'b1; inst = ADDI_X1;
    tick(); inst = ADD_X4; #1 chk("t3_ready0", inst_ready, 1);
    tick(); inst_valid = 1'b0; chk("t3_no_stall", inst_ready, 1);
    tick(); chk("t3_add_ex", ctrl_ex, 'h611); chk("t3_fwd", {fwd_a, fwd_b}, 4'b0101);
    repeat (3) tick();

    // same dependence without forwarding: stall until ADDI leaves WB
    nf_valid = 1'b1; nf_inst = ADDI_X1;
    tick(); nf_inst = ADD_X4;
    tick(); nf_valid = 1'b0;
    stalls = 0; found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (nf_ctrl_ex == 11'h611) begin found = 1'b1; break; end
      if (!nf_ready) stalls++;
      tick();
    end
    chk("t3nf_add_reached_ex", found, 1);
    chk("t3nf_stall_cycles", stalls, 3);
    chk("t3nf_fwd", {nf_fwd_a, nf_fwd_b}, 0);
    repeat (3) tick();

    // branch flush kills an illegal instruction waiting in ID
    inst_valid = 1'b1; inst = BEQ_I;
    tick(); inst = BAD_OP;
    tick(); chk("t4_beq_ex", ctrl_ex, 'h532);
    inst_valid = 1'b0; flush = 1'b1; #1 chk("t4_ready_flush", inst_ready, 1);
    tick(); flush = 1'b0;
    chk("t4_ex_bubble", ctrl_ex, 0); chk("t4_no_illegal", illegal, 0);
    chk("t4_beq_mem", ctrl_mem, 'h532);
    tick(); chk("t4_id_empty", ctrl_ex, 0); chk("t4_no_illegal2", illegal, 0);
    chk("t4_beq_wb", ctrl_wb, 'h532);
    repeat (2) tick();

    // flush overrides a load-use stall
    inst_valid = 1'b1; inst = LW_X2;
    tick(); inst = ADD_X3;
    tick(); inst_valid = 1'b0; chk("t4h_stall", inst_ready, 0);
    flush = 1'b1; #1 chk("t4h_ready_forced", inst_ready, 1);
    tick(); flush = 1'b0;
    chk("t4h_ex_bubble", ctrl_ex, 0); chk("t4h_lw_mem", ctrl_mem, 'h7D9);
    tick(); chk("t4h_add_killed", ctrl_ex, 0);
    repeat (3) tick();

    // memory stall freezes the pipe with SW in MEM
    inst_valid = 1'b1; inst = SW_I;
    tick(); inst = ADDI_X5;
    tick(); inst_valid = 1'b0;
    tick(); chk("t5_sw_mem", ctrl_mem, 'h798); chk("t5_addi_ex", ctrl_ex, 'h711);
    mem_stall = 1'b1; inst_valid = 1'b1; inst = ADD_X4;
    #1 chk("t5_ready_low", inst_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_mem", ctrl_mem, 'h798); chk("t5_hold_f3", funct3_mem, 2);
      chk("t5_hold_ex", ctrl_ex, 'h711); chk("t5_hold_wb", ctrl_wb, 0);
      chk("t5_hold_ready", inst_ready, 0);
    end
    mem_stall = 1'b0; inst_valid = 1'b0;
    tick(); chk("t5_resume_wb", ctrl_wb, 'h798); chk("t5_resume_mem", ctrl_mem, 'h711);
    chk("t5_resume_ex", ctrl_ex, 0);
    tick(); chk("t5_add_not_taken", ctrl_ex, 0);
    repeat (3) tick();

    // illegal opcode and illegal load size
    inst_valid = 1'b1; inst = BAD_OP;
    tick(); inst = LD_BAD;
    tick(); inst_valid = 1'b0;
    chk("t6_ill_op", illegal, 1); chk("t6_ill_op_ex", ctrl_ex, 0);
    tick(); chk("t6_ill_ld", illegal, 1); chk("t6_ill_ld_ex", ctrl_ex, 0);
    tick(); chk("t6_ill_end", illegal, 0);

    // asynchronous reset with a full pipe
    inst_valid = 1'b1; inst = ADDI_X1;
    repeat (4) tick();
    chk("t6_full", {ctrl_ex, ctrl_mem, ctrl_wb}, {11'h711, 11'h711, 11'h711});
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_ctrl", {ctrl_ex, ctrl_mem, ctrl_wb}, 0);
    chk("t6_rst_rd", rd_wb, 0);
    inst_valid = 1'b0;
    #1 rst_n = 1'b1;
    tick(); chk("t6_post_rst_ex", ctrl_ex, 0); chk("t6_post_rst_ready", inst_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
